dtree_walk_ctrl: RTL and testbench
==================================

# dtree_walk_ctrl

Sequential decision-tree evaluation controller for the printed-classifier flow. It time-shares one comparator across all tree nodes by walking a programmable node table one node per clock. It replaces a fully unrolled combinational comparator tree where area matters more than latency. Samples arrive over a valid/ready handshake; class results leave over a second valid/ready handshake. Tree contents are loaded through a simple write port.

## Interface
- NUM_FEAT, 4, number of input features
- FEAT_W, 8, feature width in bits
- CLASS_W, 2, class label width
- NODE_AW, 6, node table address width (2^NODE_AW entries)
- MAX_DEPTH, 16, maximum node visits before a walk aborts
- Derived: FIDX_W = $clog2(NUM_FEAT); NODE_W = 1 + FIDX_W + 3 + FEAT_W + 2*NODE_AW (26 at defaults)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  node table write strobe
- cfg_addr  in  NODE_AW  node index to write
- cfg_wdata  in  NODE_W  node word: [MSB] leaf, then feat idx, prec-1 (3b), thr (FEAT_W), left (NODE_AW), right (NODE_AW, LSBs)
- cfg_busy  out  1  high when the state is not IDLE
- in_valid  in  1  sample valid
- in_ready  out  1  high in IDLE only
- in_x  in  NUM_FEAT*FEAT_W  features; feature i at bits [i*FEAT_W +: FEAT_W]
- out_valid  out  1  result valid
- out_ready  in  1  result accepted
- out_class  out  CLASS_W  class label
- out_err  out  1  walk aborted at MAX_DEPTH

## Operation
- Node table: register array of 2^NODE_AW words. Cleared to zero on reset. Read combinationally.
- A write is applied at the clock edge only when cfg_we=1 and the state is IDLE. Writes in WALK or DONE are dropped silently.
- A write in the same cycle as a sample accept is applied; the walk sees the new word.
- State machine (reset state IDLE):
  - IDLE: in_ready=1. On in_valid&in_ready: latch in_x, set ptr=0 and depth=0, go to WALK.
  - WALK: read node[ptr].
    - Leaf: out_class = thr[CLASS_W-1:0], out_err=0, go to DONE.
    - Otherwise, with p = prec+1 (1..8) and field = x[feat][FEAT_W-1 -: p] zero-extended: if field <= thr (unsigned, full FEAT_W compare), ptr=left, else ptr=right. Then depth++.
    - If a non-leaf visit would make depth == MAX_DEPTH: out_class=0, out_err=1, go to DONE.
  - DONE: out_valid=1. out_class and out_err hold stable until out_ready=1. Then go to IDLE.
- A feature index >= NUM_FEAT selects feature 0.
- An all-zero table is a self-loop at node 0, so it must end in out_err=1.

## Timing
- Reset values: in_ready=1, cfg_busy=0, out_valid=0, out_class=0, out_err=0, ptr=0, depth=0.
- Latency: out_valid rises d+1 edges after the accept edge, where d is the number of internal nodes visited. A root leaf gives 1 edge.
- Error case: out_valid rises MAX_DEPTH edges after the accept edge.
- Throughput: one sample per d+3 cycles when out_ready is held high.
- If out_ready=1 in the first DONE cycle, out_valid is high for exactly one cycle. The next accept happens no earlier than the following cycle.
- in_ready is low in WALK and DONE; inputs are ignored there.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to any output.
- Asynchronous reset mid-walk or in DONE: return to IDLE immediately, drop the sample, clear out_valid and the node table.

## Configuration
- DTREE_STATS_EN: defined
  - Adds ports stat_clr (in, 1), stat_samples (out, 16) and stat_cycles (out, 16).
  - stat_samples increments on each result handshake.
  - stat_cycles increments on every WALK cycle.
  - Both counters saturate at 16'hFFFF. Synchronous stat_clr zeroes them, with priority over an increment in the same cycle. Both reset to 0.
- DTREE_STATS_EN: undefined
  - The ports and counters are absent; the rest of the behaviour is identical.

## Test plan
- Program node0 = internal (feat0, prec=2, thr=0, left=1, right=2), node1 = leaf class1, node2 = leaf class2. Send X0=0x3F -> out_class=1, out_err=0, out_valid 2 edges after accept.
- Same tree, X0=0x40 -> out_class=2. Then X0=0xC0 with node0 thr=3 -> out_class=1 (field 3 <= 3).
- No programming after reset, send any sample -> out_err=1, out_class=0, out_valid 16 edges after accept.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_class stable, in_ready=0. A cfg_we to node1 during that window is dropped: a re-run gives the same class.
- Assert rst_n=0 mid-walk -> out_valid=0 and in_ready=1 immediately; the next sample without reprogramming gives out_err=1.
- With DTREE_STATS_EN: 3 samples through the two-level tree -> stat_samples=3, stat_cycles=6. stat_clr -> both 0 next cycle.

Source files
------------

// File: rtl/dtree_walk_ctrl.sv
// dtree_walk_ctrl: walks a programmable decision-tree node table one node per clock, sharing one comparator.
// Optional feature macro DTREE_STATS_EN adds saturating sample / walk-cycle counters with a synchronous clear.
module dtree_walk_ctrl #(
  parameter int NUM_FEAT  = 4,
  parameter int FEAT_W    = 8,
  parameter int CLASS_W   = 2,
  parameter int NODE_AW   = 6,
  parameter int MAX_DEPTH = 16,
  parameter int FIDX_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1,
  parameter int NODE_W    = 1 + FIDX_W + 3 + FEAT_W + 2*NODE_AW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [NODE_AW-1:0]           cfg_addr,
  input  logic [NODE_W-1:0]            cfg_wdata,
  output logic                         cfg_busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FEAT*FEAT_W-1:0]   in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CLASS_W-1:0]           out_class,
  output logic                         out_err
`ifdef DTREE_STATS_EN
  ,
  input  logic                         stat_clr,
  output logic [15:0]                  stat_samples,
  output logic [15:0]                  stat_cycles
`endif
);

  localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1);
  localparam int TBL_N    = 1 << NODE_AW;
  localparam int THR_LSB  = 2*NODE_AW;
  localparam int PREC_LSB = THR_LSB + FEAT_W;
  localparam int FIDX_LSB = PREC_LSB + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [NODE_W-1:0]            node_tbl [TBL_N];
  logic [NODE_AW-1:0]           ptr;
  logic [NODE_AW-1:0]           ptr_next;
  logic [DEPTH_W-1:0]           depth;
  logic [DEPTH_W-1:0]           depth_next;
  logic [CLASS_W-1:0]           class_q;
  logic [CLASS_W-1:0]           class_next;
  logic                         err_q;
  logic                         err_next;
  logic [NUM_FEAT*FEAT_W-1:0]   x_q;
  logic                         accept;
  logic                         tbl_we;

  logic [NODE_W-1:0]            node;
  logic                         node_leaf;
  logic [FIDX_W-1:0]            node_fidx;
  logic [2:0]                   node_prec;
  logic [FEAT_W-1:0]            node_thr;
  logic [NODE_AW-1:0]           node_left;
  logic [NODE_AW-1:0]           node_right;
  logic [FEAT_W-1:0]            feat_val;
  logic                         go_left;

  // Keep only the top (prec+1) bits of the feature, right-aligned (zero-extended).
  function automatic logic [FEAT_W-1:0] prec_field(input logic [FEAT_W-1:0] v,
                                                   input logic [2:0] prec);
    int p;
    p = int'(prec) + 1;
    if (p >= FEAT_W) return v;
    return v >> (FEAT_W - p);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  assign in_ready  = (state == IDLE);
  assign cfg_busy  = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_class = class_q;
  assign out_err   = err_q;
  assign accept    = in_valid && (state == IDLE);
  assign tbl_we    = cfg_we && (state == IDLE);

  assign node       = node_tbl[ptr];
  assign node_leaf  = node[NODE_W-1];
  assign node_fidx  = node[FIDX_LSB +: FIDX_W];
  assign node_prec  = node[PREC_LSB +: 3];
  assign node_thr   = node[THR_LSB +: FEAT_W];
  assign node_left  = node[NODE_AW +: NODE_AW];
  assign node_right = node[0 +: NODE_AW];

  // Out-of-range feature indices fall through to feature 0.
  always_comb begin
    feat_val = x_q[0 +: FEAT_W];
    for (int i = 1; i < NUM_FEAT; i++) begin
      if (int'(node_fidx) == i) feat_val = x_q[i*FEAT_W +: FEAT_W];
    end
  end

  assign go_left = (prec_field(feat_val, node_prec) <= node_thr);

  // Node table: cleared by reset, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_N; i++) node_tbl[i] <= '0;
    end else if (tbl_we) begin
      node_tbl[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) x_q <= in_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      depth   <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      depth   <= depth_next;
      class_q <= class_next;
      err_q   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    depth_next = depth;
    class_next = class_q;
    err_next   = err_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = WALK;
          ptr_next   = '0;
          depth_next = '0;
        end
      end
      WALK: begin
        if (node_leaf) begin
          class_next = node_thr[CLASS_W-1:0];
          err_next   = 1'b0;
          state_next = DONE;
        end else if (depth == DEPTH_W'(MAX_DEPTH - 1)) begin
          // This visit would reach the depth limit: abort the walk.
          class_next = '0;
          err_next   = 1'b1;
          depth_next = depth + 1'b1;
          state_next = DONE;
        end else begin
          ptr_next   = go_left ? node_left : node_right;
          depth_next = depth + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DTREE_STATS_EN
  logic [15:0] samples_q;
  logic [15:0] cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples_q <= '0;
      cycles_q  <= '0;
    end else if (stat_clr) begin
      samples_q <= '0;
      cycles_q  <= '0;
    end else begin
      samples_q <= sat_inc(samples_q, (state == DONE) && out_ready);
      cycles_q  <= sat_inc(cycles_q, (state == WALK));
    end
  end

  assign stat_samples = samples_q;
  assign stat_cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_dtree_walk_ctrl.sv
// Self-checking bench for dtree_walk_ctrl: directed scenarios plus random trees checked against a node-walk model.
module tb_dtree_walk_ctrl;
  localparam int NUM_FEAT  = 4;
  localparam int FEAT_W    = 8;
  localparam int CLASS_W   = 2;
  localparam int NODE_AW   = 6;
  localparam int MAX_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [25:0] cfg_wdata = '0;
  logic        cfg_busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_class;
  logic        out_err;
`ifdef DTREE_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_samples;
  logic [15:0] stat_cycles;
`endif

  int checks = 0;
  int failures = 0;
  logic [25:0] tmem [64];

  dtree_walk_ctrl #(
    .NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
    .NODE_AW(NODE_AW), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err)
`ifdef DTREE_STATS_EN
    , .stat_clr(stat_clr), .stat_samples(stat_samples), .stat_cycles(stat_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] mk_node(input int leaf, input int fidx, input int precm1,
                                          input int thr, input int left, input int right);
    logic [25:0] w;
    w = (26'(leaf & 1) << 25) | (26'(fidx & 3) << 23) | (26'(precm1 & 7) << 20) |
        (26'(thr & 255) << 12) | (26'(left & 63) << 6) | 26'(right & 63);
    return w;
  endfunction

  // Reference walk: decode each word arithmetically and follow the tree up to MAX_DEPTH visits.
  function automatic void model(input logic [31:0] x, output logic [1:0] cls,
                                output logic err, output int edges);
    int ptr, d, leaf, fidx, p, thr, xv, field;
    ptr = 0; d = 0; cls = 2'd0; err = 1'b1; edges = MAX_DEPTH;
    for (int v = 0; v < MAX_DEPTH; v++) begin
      leaf = int'(tmem[ptr] >> 25) & 1;
      fidx = int'(tmem[ptr] >> 23) & 3;
      p    = (int'(tmem[ptr] >> 20) & 7) + 1;
      thr  = int'(tmem[ptr] >> 12) & 255;
      if (leaf != 0) begin
        cls = 2'(thr % 4); err = 1'b0; edges = d + 1;
        return;
      end
      if (fidx >= NUM_FEAT) fidx = 0;
      xv    = int'(x >> (8*fidx)) & 255;
      field = xv / (1 << (8 - p));
      ptr   = (field <= thr) ? (int'(tmem[ptr] >> 6) & 63) : (int'(tmem[ptr]) & 63);
      d++;
    end
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef DTREE_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 64; i++) tmem[i] = '0;
    @(posedge clk); #1;
  endtask

  task automatic prog(input int addr, input logic [25:0] word);
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_wdata = word;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tmem[addr] = word;
  endtask

  task automatic prog_two_level(input int thr0);
    prog(0, mk_node(0, 0, 1, thr0, 1, 2));
    prog(1, mk_node(1, 0, 0, 1, 0, 0));
    prog(2, mk_node(1, 0, 0, 2, 0, 0));
  endtask

  // Sends one sample, counts edges from accept to out_valid (100 = timed out), then accepts the result.
  task automatic run_sample(input logic [31:0] x, output int edges,
                            output logic [1:0] cls, output logic err);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; in_x = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 100) begin @(posedge clk); #1; edges++; end
    cls = out_class; err = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({in_ready, cfg_busy, out_valid, out_class, out_err} !== {1'b1, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b busy=%b vld=%b cls=%0d err=%b exp 1 0 0 0 0",
               in_ready, cfg_busy, out_valid, out_class, out_err);
    end
`ifdef DTREE_STATS_EN
    checks++;
    if (stat_samples !== 16'd0 || stat_cycles !== 16'd0) begin
      failures++;
      $display("FAIL reset_stats got samples=%0d cycles=%0d exp 0 0", stat_samples, stat_cycles);
    end
`endif
  endtask

  task automatic test_two_level();
    int e; logic [1:0] c; logic er;
    prog_two_level(0);
    run_sample(32'h0000_003F, e, c, er);
    checks++;
    if (c !== 2'd1 || er !== 1'b0) begin
      failures++; $display("FAIL two_level_3f got cls=%0d err=%b exp 1 0", c, er);
    end
    checks++;
    if (e != 2) begin failures++; $display("FAIL two_level_latency got=%0d exp=2", e); end
    run_sample(32'h0000_0040, e, c, er);
    checks++;
    if (c !== 2'd2 || er !== 1'b0 || e != 2) begin
      failures++; $display("FAIL two_level_40 got cls=%0d err=%b edges=%0d exp 2 0 2", c, er, e);
    end
    prog(0, mk_node(0, 0, 1, 3, 1, 2));
    run_sample(32'h0000_00C0, e, c, er);
    checks++;
    if (c !== 2'd1 || er !== 1'b0) begin
      failures++; $display("FAIL two_level_thr3 got cls=%0d err=%b exp 1 0", c, er);
    end
  endtask

  task automatic test_empty_err();
    int e; logic [1:0] c; logic er;
    apply_reset();
    run_sample($urandom, e, c, er);
    checks++;
    if (c !== 2'd0 || er !== 1'b1) begin
      failures++; $display("FAIL empty_err got cls=%0d err=%b exp 0 1", c, er);
    end
    checks++;
    if (e != MAX_DEPTH) begin failures++; $display("FAIL empty_latency got=%0d exp=%0d", e, MAX_DEPTH); end
  endtask

  task automatic test_hold_done();
    int e, guard; logic [1:0] c; logic er;
    apply_reset();
    prog_two_level(0);
    in_valid = 1'b1; in_x = 32'h0000_003F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({out_valid, in_ready, out_class, out_err} !== {1'b1, 1'b0, 2'd1, 1'b0}) begin
        failures++;
        $display("FAIL hold_done cyc%0d got vld=%b rdy=%b cls=%0d err=%b exp 1 0 1 0",
                 k, out_valid, in_ready, out_class, out_err);
      end
      if (k == 2) begin
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = mk_node(1, 0, 0, 3, 0, 0);
      end else begin
        cfg_we = 1'b0;
      end
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_sample(32'h0000_003F, e, c, er);
    checks++;
    if (c !== 2'd1 || er !== 1'b0) begin
      failures++; $display("FAIL dropped_write got cls=%0d err=%b exp 1 0", c, er);
    end
  endtask

  task automatic test_async_reset();
    int e, guard; logic [1:0] c; logic er;
    apply_reset();
    prog_two_level(0);
    in_valid = 1'b1; in_x = 32'h0000_003F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL walk_busy got busy=%b rdy=%b exp 1 0", cfg_busy, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_walk got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 64; i++) tmem[i] = '0;
    @(posedge clk); #1;
    run_sample($urandom, e, c, er);
    checks++;
    if (c !== 2'd0 || er !== 1'b1 || e != MAX_DEPTH) begin
      failures++; $display("FAIL rst_cleared_tbl got cls=%0d err=%b edges=%0d exp 0 1 16", c, er, e);
    end
    in_valid = 1'b1; in_x = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_done got vld=%b rdy=%b err=%b exp 0 1 0", out_valid, in_ready, out_err);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int e, me; logic [1:0] c, mc; logic er, merr; logic [31:0] x;
    apply_reset();
    for (int s = 0; s < 40; s++) begin
      if (s % 8 == 0) begin
        for (int n = 0; n < 16; n++) begin
          prog(n, mk_node(($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 3),
                          $urandom_range(0, 7), $urandom_range(0, 255),
                          $urandom_range(0, 15), $urandom_range(0, 15)));
        end
      end
      x = $urandom;
      model(x, mc, merr, me);
      run_sample(x, e, c, er);
      checks++;
      if (c !== mc || er !== merr || e != me) begin
        failures++;
        $display("FAIL random s%0d x=%h got cls=%0d err=%b edges=%0d exp %0d %b %0d",
                 s, x, c, er, e, mc, merr, me);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc[$]; int me, per; bit dbl; bit prev; int badcls;
    logic [1:0] mc; logic merr; logic [31:0] x;
    apply_reset();
    prog_two_level(0);
    x = $urandom;
    model(x, mc, merr, me);
    per = me + 2;
    dbl = 1'b0; prev = 1'b0; badcls = 0;
    in_x = x; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (in_ready) acc.push_back(cyc);
      if (out_valid && prev) dbl = 1'b1;
      if (out_valid && out_class !== mc) badcls++;
      prev = out_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (acc.size() < 3) begin
      failures++; $display("FAIL b2b_accepts got=%0d exp>=3", acc.size());
    end else if (acc[1] - acc[0] != per || acc[2] - acc[1] != per) begin
      failures++;
      $display("FAIL b2b_period got=%0d,%0d exp=%0d", acc[1] - acc[0], acc[2] - acc[1], per);
    end
    checks++;
    if (dbl || badcls != 0) begin
      failures++; $display("FAIL b2b_outputs got dbl=%0d badcls=%0d exp 0 0", dbl, badcls);
    end
  endtask

`ifdef DTREE_STATS_EN
  task automatic test_stats();
    int e; logic [1:0] c; logic er;
    apply_reset();
    prog_two_level(0);
    for (int s = 0; s < 3; s++) run_sample($urandom, e, c, er);
    checks++;
    if (stat_samples !== 16'd3 || stat_cycles !== 16'd6) begin
      failures++; $display("FAIL stats_count got samples=%0d cycles=%0d exp 3 6", stat_samples, stat_cycles);
    end
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    checks++;
    if (stat_samples !== 16'd0 || stat_cycles !== 16'd0) begin
      failures++; $display("FAIL stats_clr got samples=%0d cycles=%0d exp 0 0", stat_samples, stat_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_level();
    test_empty_err();
    test_hold_done();
    test_async_reset();
    test_random();
    test_back_to_back();
`ifdef DTREE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
